// File: rtl/sopc_button_pio_debounced.sv
// sopc_button_pio_debounced: Avalon-MM button PIO with per-bit sync, debounce, edge capture and IRQ mask.
module sopc_button_pio_debounced #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d;
  logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d, rise_q, rise_d, fall_q, fall_d;
  logic [WIDTH-1:0] ev, wd, sel;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [31:0]      readdata_d;
  logic             wr;
  logic             unused_wd;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign wr        = chipselect & ~write_n;
  assign irq       = |(cap_q & mask_q);
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    ev     = (rise_q & ~stable_q & stable_d) | (fall_q & stable_q & ~stable_d);
    // a new event overrides a same-cycle clear so no edge is lost
    cap_d  = (cap_q & ~((wr && address == 3'd3) ? wd : '0)) | ev;
    mask_d = (wr && address == 3'd2) ? wd : mask_q;
    rise_d = (wr && address == 3'd4) ? wd : rise_q;
    fall_d = (wr && address == 3'd5) ? wd : fall_q;
    sel    = address == 3'd0 ? stable_q :
             address == 3'd1 ? sync2_q  :
             address == 3'd2 ? mask_q   :
             address == 3'd3 ? cap_q    :
             address == 3'd4 ? rise_q   :
             address == 3'd5 ? fall_q   : '0;
    readdata_d = 32'(sel);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      mask_q   <= '0;
      cap_q    <= '0;
      rise_q   <= '1;
      fall_q   <= '0;
      readdata <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= in_port;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      readdata <= readdata_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: tb/tb_sopc_button_pio_debounced.sv
// tb_sopc_button_pio_debounced: directed self-checking bench (WIDTH=4, DEBOUNCE_CYCLES=4).
module tb_sopc_button_pio_debounced;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = '0;
  logic [31:0] readdata;
  logic        irq;
  int          errors = 0;
  int          checks = 0;
  sopc_button_pio_debounced #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    tick();
    check(tag, readdata, exp);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  initial begin
    // reset state
    tick(2);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    rd("rst_rise_en", 3'd4, 32'hF);
    rd("rst_fall_en", 3'd5, 32'h0);
    rd("rst_mask", 3'd2, 32'h0);
    rd("rst_edge_cap", 3'd3, 32'h0);
    rd("rst_unmapped", 3'd6, 32'h0);
    // single step on bit0: stable updates on edge 6, readdata one edge later
    rd("data_idle", 3'd0, 32'h0);
    in_port = 4'h1;
    tick(6);
    check("data_edge6_old", readdata, 32'h0);
    tick();
    check("data_edge7_new", readdata, 32'h1);
    check("irq_masked", {31'b0, irq}, 32'h0);
    rd("cap_bit0", 3'd3, 32'h1);
    // glitch of 3 clocks rejected, 4 clocks accepted
    address = 3'd0;
    in_port = 4'h5;
    tick(3);
    in_port = 4'h1;
    tick(10);
    rd("glitch3_data", 3'd0, 32'h1);
    rd("glitch3_cap", 3'd3, 32'h1);
    address = 3'd0;
    in_port = 4'h5;
    tick(4);
    in_port = 4'h1;
    tick(3);
    check("pulse4_data_high", readdata, 32'h5);
    tick(12);
    rd("pulse4_data_after", 3'd0, 32'h1);
    rd("pulse4_cap", 3'd3, 32'h5);
    // falling-edge capture on bit1 with IRQ
    wr(3'd5, 32'h2);
    wr(3'd4, 32'h0);
    wr(3'd2, 32'h2);
    wr(3'd3, 32'hF);
    rd("cap_cleared", 3'd3, 32'h0);
    in_port = 4'h3;
    tick(10);
    rd("rise_disabled", 3'd3, 32'h0);
    in_port = 4'h1;
    tick(10);
    rd("fall_cap", 3'd3, 32'h2);
    check("fall_irq", {31'b0, irq}, 32'h1);
    wr(3'd3, 32'h0);
    check("w1c_zero_irq", {31'b0, irq}, 32'h1);
    rd("w1c_zero_cap", 3'd3, 32'h2);
    wr(3'd3, 32'h2);
    check("w1c_irq_clear", {31'b0, irq}, 32'h0);
    rd("w1c_cap_clear", 3'd3, 32'h0);
    // W1C on the same edge as a new capture: set wins
    wr(3'd4, 32'h1);
    in_port = 4'h0;
    tick(10);
    rd("bit0_fall_nocap", 3'd3, 32'h0);
    in_port = 4'h1;
    tick(5);
    wr(3'd3, 32'h1);
    rd("set_wins", 3'd3, 32'h1);
    rd("set_wins_data", 3'd0, 32'h1);
    // async reset mid-count with IRQ pending
    wr(3'd2, 32'h1);
    check("pend_irq", {31'b0, irq}, 32'h1);
    address = 3'd3;
    in_port = 4'h3;
    tick(4);
    check("mid_count", 32'(dut.cnt_q[1]), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_irq", {31'b0, irq}, 32'h0);
    check("arst_readdata", readdata, 32'h0);
    check("arst_cap", 32'(dut.cap_q), 32'h0);
    check("arst_cnt", 32'(dut.cnt_q[1]), 32'h0);
    tick(2);
    reset_n = 1'b1;
    rd("arst_rise_en", 3'd4, 32'hF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
